div: RTL and testbench

- Iterative integer divider; the inverse-direction companion to the pipelined multiplier in the motor-controller FPGA arithmetic path.
- Same start/done request style as the multiplier, so control FSMs can issue multiply and divide operations identically. Typical use: current/speed scaling and normalisation.
- Computes quotient and remainder of a/b with one restoring-division step per clock.
- Latency is fixed and data-independent.

---
 rtl/div_if.sv | 23 ++
 rtl/div.sv | 194 +++++++++++++++++++
 tb/tb_div.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/div_if.sv
// Request/result bundle for the iterative divider.
//   a, b   : dividend and divisor, sampled when start is accepted
//   start  : operation request
//   q, r   : quotient and remainder, held until the next accepted start
//   dbz    : divide-by-zero flag for the held result
//   busy   : operation in progress; start is ignored while high
//   done   : single-cycle result-valid pulse
// master = requester, slave = divider.
interface div_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             start;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             dbz;
    logic             busy;
    logic             done;

    modport master (output a, b, start, input q, r, dbz, busy, done);
    modport slave  (input a, b, start, output q, r, dbz, busy, done);
endinterface

// File: rtl/div.sv
// Iterative restoring divider, one quotient bit per clock.
// Sequence IDLE -> LOAD -> RUN (WIDTH clocks) -> FIX -> IDLE.
// done pulses exactly WIDTH+2 clocks after the accepting edge, whatever the operands.
// Ports:
//   c   : clock
//   rst : synchronous active-high reset; it wins over start and aborts a running operation
//   bus : div_if slave (a, b, start in; q, r, dbz, busy, done out, all registered)
// SIGNED=1 divides two's-complement operands and truncates toward zero.
// The remainder takes the sign of the dividend.
module div #(
    parameter int WIDTH  = 32,
    parameter bit SIGNED = 1'b0
) (
    input  logic c,
    input  logic rst,
    div_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        FIX  = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WIDTH-1:0] a_r;          // operands exactly as captured
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] dvd_r;        // dividend magnitude; quotient bits shift in from the LSB
    logic [WIDTH-1:0] dvs_r;        // divisor magnitude
    logic [WIDTH-1:0] rem_r;        // partial remainder
    logic [CW-1:0]    cnt_r;
    logic             q_sign_r;
    logic             r_sign_r;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] r_r;
    logic             dbz_r;
    logic             busy_r;
    logic             done_r;
    logic             accept_s;
    logic [WIDTH:0]   shift_s;
    logic [WIDTH:0]   diff_s;
    logic             ge_s;
    logic [WIDTH:0]   rem_nxt_s;
    logic [WIDTH-1:0] q_fix_s;
    logic [WIDTH-1:0] r_fix_s;

    // The most-negative input maps to itself here.
    // Read as unsigned, that is the correct magnitude.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        if (SIGNED && v[WIDTH-1]) begin
            magnitude = -v;
        end else begin
            magnitude = v;
        end
    endfunction

    // busy also blocks start during the done cycle, when the FSM is already back in IDLE.
    assign accept_s = (state_r == IDLE) && bus.start && !busy_r;

    // State register
    always_ff @(posedge c) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = LOAD;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LOAD: state_nxt_s = RUN;
            RUN: begin
                if (cnt_r == LAST) begin
                    state_nxt_s = FIX;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            FIX:     state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // One restoring step: shift in the next dividend bit, then trial-subtract the divisor.
    // The value that is kept is always below the divisor.
    // Its top bit is therefore zero and is dropped on writeback.
    always_comb begin
        shift_s   = {rem_r, dvd_r[WIDTH-1]};
        diff_s    = shift_s - {1'b0, dvs_r};
        ge_s      = (shift_s >= {1'b0, dvs_r});
        rem_nxt_s = shift_s;
        if (ge_s) begin
            rem_nxt_s = diff_s;
        end else begin
            rem_nxt_s = shift_s;
        end
    end

    // Final result: either the divide-by-zero pattern or the sign-corrected magnitudes
    always_comb begin
        q_fix_s = dvd_r;
        r_fix_s = rem_r;
        if (b_r == {WIDTH{1'b0}}) begin
            q_fix_s = {WIDTH{1'b1}};
            r_fix_s = a_r;
        end else begin
            if (q_sign_r) begin
                q_fix_s = -dvd_r;
            end else begin
                q_fix_s = dvd_r;
            end
            if (r_sign_r) begin
                r_fix_s = -rem_r;
            end else begin
                r_fix_s = rem_r;
            end
        end
    end

    // Datapath, result and handshake registers
    always_ff @(posedge c) begin
        if (rst) begin
            a_r      <= {WIDTH{1'b0}};
            b_r      <= {WIDTH{1'b0}};
            dvd_r    <= {WIDTH{1'b0}};
            dvs_r    <= {WIDTH{1'b0}};
            rem_r    <= {WIDTH{1'b0}};
            cnt_r    <= {CW{1'b0}};
            q_sign_r <= 1'b0;
            r_sign_r <= 1'b0;
            q_r      <= {WIDTH{1'b0}};
            r_r      <= {WIDTH{1'b0}};
            dbz_r    <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        a_r    <= bus.a;
                        b_r    <= bus.b;
                        busy_r <= 1'b1;
                    end else if (done_r) begin
                        busy_r <= 1'b0;
                    end else begin
                        busy_r <= busy_r;
                    end
                end
                LOAD: begin
                    dvd_r    <= magnitude(a_r);
                    dvs_r    <= magnitude(b_r);
                    rem_r    <= {WIDTH{1'b0}};
                    cnt_r    <= {CW{1'b0}};
                    q_sign_r <= SIGNED && (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
                    r_sign_r <= SIGNED && a_r[WIDTH-1];
                end
                RUN: begin
                    rem_r <= WIDTH'(rem_nxt_s);
                    dvd_r <= {dvd_r[WIDTH-2:0], ge_s};
                    cnt_r <= cnt_r + CW'(1);
                end
                FIX: begin
                    q_r    <= q_fix_s;
                    r_r    <= r_fix_s;
                    dbz_r  <= (b_r == {WIDTH{1'b0}});
                    done_r <= 1'b1;
                end
                default: begin
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.q    = q_r;
    assign bus.r    = r_r;
    assign bus.dbz  = dbz_r;
    assign bus.busy = busy_r;
    assign bus.done = done_r;
endmodule

// File: tb/tb_div.sv
// Bench for div: one unsigned instance and one signed instance, both at WIDTH=32.
// Expected results come from plain integer division in the bench.
// Inputs change on the falling edge; outputs are read on the falling edge.
module tb_div;
    localparam int W   = 32;
    localparam int LAT = W + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    div_if #(.WIDTH(W)) if_u ();
    div_if #(.WIDTH(W)) if_s ();

    div #(.WIDTH(W), .SIGNED(1'b0)) u_div_u (.c(clk), .rst(rst), .bus(if_u.slave));
    div #(.WIDTH(W), .SIGNED(1'b1)) u_div_s (.c(clk), .rst(rst), .bus(if_s.slave));

    always #5 clk = ~clk;

    // Reference: truncating integer division; b == 0 gives all ones and the dividend
    task automatic ref_div(input bit sgn, input logic [31:0] av, input logic [31:0] bv,
                           output logic [31:0] qo, output logic [31:0] ro, output logic dz);
        longint sa;
        longint sb;
        dz = (bv == 32'd0);
        if (dz) begin
            qo = 32'hFFFF_FFFF;
            ro = av;
        end else if (!sgn) begin
            qo = av / bv;
            ro = av % bv;
        end else begin
            sa = longint'($signed(av));
            sb = longint'($signed(bv));
            qo = 32'(sa / sb);
            ro = 32'(sa % sb);
        end
    endtask

    task automatic drive(input bit sel, input logic [31:0] av, input logic [31:0] bv, input logic st);
        if_u.a = av; if_u.b = bv; if_s.a = av; if_s.b = bv;
        if (sel) if_s.start = st; else if_u.start = st;
    endtask

    function automatic logic done_of(input bit sel);
        return sel ? if_s.done : if_u.done;
    endfunction

    // Entered on the falling edge just after the accepting edge.
    // lat counts rising edges after the accepting edge.
    task automatic wait_done(input bit sel, output int lat);
        lat = 0;
        while (lat < 100 && !done_of(sel)) begin
            @(posedge clk); lat++; @(negedge clk);
        end
    endtask

    // Issue one operation, scramble a/b after accept, and return what the DUT produced
    task automatic do_op(input bit sel, input logic [31:0] av, input logic [31:0] bv,
                         output logic [31:0] qo, output logic [31:0] ro, output logic dz, output int lat);
        drive(sel, av, bv, 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive(sel, $urandom, $urandom, 1'b0);
        wait_done(sel, lat);
        qo = sel ? if_s.q : if_u.q;
        ro = sel ? if_s.r : if_u.r;
        dz = sel ? if_s.dbz : if_u.dbz;
    endtask

    task automatic check_op(input string name, input bit sel, input logic [31:0] av, input logic [31:0] bv);
        logic [31:0] q, r, eq, er;
        logic dz, edz;
        int lat;
        ref_div(sel, av, bv, eq, er, edz);
        do_op(sel, av, bv, q, r, dz, lat);
        n_checks++;
        if ({q, r, dz} !== {eq, er, edz}) begin
            n_fail++;
            $display("FAIL %s a=%h b=%h: got q=%h r=%h dbz=%b, expected q=%h r=%h dbz=%b",
                     name, av, bv, q, r, dz, eq, er, edz);
        end
        n_checks++;
        if (lat !== LAT) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d expected %0d", name, lat, LAT);
        end
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive(1'b0, 32'd0, 32'd0, 1'b0);
        drive(1'b1, 32'd0, 32'd0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({if_u.q, if_u.r, if_u.dbz, if_u.busy, if_u.done, if_s.q, if_s.r, if_s.dbz, if_s.busy, if_s.done} !== 134'd0) begin
            n_fail++;
            $display("FAIL reset_state: got u q=%h r=%h dbz=%b busy=%b done=%b s q=%h r=%h, expected all zero",
                     if_u.q, if_u.r, if_u.dbz, if_u.busy, if_u.done, if_s.q, if_s.r);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_unsigned_basic;
        logic [31:0] q, r;
        logic dz;
        int lat;
        do_op(1'b0, 32'd100, 32'd7, q, r, dz, lat);
        n_checks++;
        if ({q, r, dz} !== {32'd14, 32'd2, 1'b0}) begin
            n_fail++;
            $display("FAIL unsigned_100_7: got q=%0d r=%0d dbz=%b expected q=14 r=2 dbz=0", q, r, dz);
        end
        n_checks++;
        if (lat !== LAT) begin
            n_fail++;
            $display("FAIL unsigned_latency: got %0d expected %0d", lat, LAT);
        end
        n_checks++;
        if (if_u.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_in_done_cycle: got %b expected 1", if_u.busy);
        end
        @(negedge clk);
        n_checks++;
        if ({if_u.busy, if_u.done, if_u.q} !== {1'b0, 1'b0, 32'd14}) begin
            n_fail++;
            $display("FAIL after_done: got busy=%b done=%b q=%0d expected busy=0 done=0 q=14",
                     if_u.busy, if_u.done, if_u.q);
        end
    endtask

    task automatic test_unsigned_extremes;
        check_op("u_max_div_1", 1'b0, 32'hFFFF_FFFF, 32'd1);
        check_op("u_small_div_max", 1'b0, 32'd5, 32'hFFFF_FFFF);
        check_op("u_equal", 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        for (int i = 0; i < 8; i++) begin
            check_op("u_random", 1'b0, $urandom, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 300)) : 32'($urandom));
        end
    endtask

    task automatic test_divide_by_zero;
        check_op("u_dbz", 1'b0, 32'h0000_1234, 32'd0);
        check_op("s_dbz_neg", 1'b1, 32'hFFFF_FFFB, 32'd0);
    endtask

    task automatic test_signed;
        check_op("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
        check_op("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE);
        check_op("s_overflow", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        check_op("s_min_div_2", 1'b1, 32'h8000_0000, 32'd2);
        check_op("s_m7_m2", 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE);
        for (int i = 0; i < 8; i++) begin
            check_op("s_random", 1'b1, $urandom, ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($signed($urandom_range(0, 2000)) - 1000));
        end
    endtask

    task automatic test_ignore_start;
        int lat;
        drive(1'b0, 32'd1000, 32'd10, 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 32'd0, 32'd0, 1'b0);
        repeat (5) @(negedge clk);
        drive(1'b0, 32'd3, 32'd1, 1'b1);
        @(negedge clk);
        drive(1'b0, 32'd3, 32'd1, 1'b0);
        wait_done(1'b0, lat);
        n_checks++;
        if ({if_u.q, if_u.r, if_u.dbz} !== {32'd100, 32'd0, 1'b0} || lat !== LAT - 6) begin
            n_fail++;
            $display("FAIL ignore_start_busy: got q=%0d r=%0d lat=%0d expected q=100 r=0 lat=%0d",
                     if_u.q, if_u.r, lat, LAT - 6);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [31:0] q, r;
        logic dz;
        int lat;
        do_op(1'b0, 32'd81, 32'd9, q, r, dz, lat);
        // start raised in the done cycle (to be ignored) and held into the following cycle
        drive(1'b0, 32'd50, 32'd5, 1'b1);
        @(negedge clk);
        n_checks++;
        if (if_u.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle_gap: got busy=%b expected 0", if_u.busy);
        end
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 32'd7, 32'd7, 1'b0);
        wait_done(1'b0, lat);
        n_checks++;
        if ({if_u.q, if_u.r, if_u.dbz} !== {32'd10, 32'd0, 1'b0} || lat !== LAT) begin
            n_fail++;
            $display("FAIL back_to_back: got q=%0d r=%0d lat=%0d expected q=10 r=0 lat=%0d",
                     if_u.q, if_u.r, lat, LAT);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midop;
        int seen;
        drive(1'b1, 32'd999, 32'd3, 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive(1'b1, 32'd0, 32'd0, 1'b0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({if_s.q, if_s.r, if_s.dbz, if_s.busy, if_s.done} !== 67'd0) begin
            n_fail++;
            $display("FAIL reset_midop: got q=%h r=%h dbz=%b busy=%b done=%b expected all zero",
                     if_s.q, if_s.r, if_s.dbz, if_s.busy, if_s.done);
        end
        seen = 0;
        repeat (45) begin
            @(negedge clk);
            if (if_s.done === 1'b1 || if_s.busy === 1'b1) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL reset_no_done: got %0d active cycles expected 0", seen);
        end
        check_op("s_after_reset", 1'b1, 32'hFFFF_FF9C, 32'd7);
    endtask

    initial begin
        if_u.a = 32'd0; if_u.b = 32'd0; if_u.start = 1'b0;
        if_s.a = 32'd0; if_s.b = 32'd0; if_s.start = 1'b0;
        @(negedge clk);
        test_reset;
        test_unsigned_basic;
        test_unsigned_extremes;
        test_divide_by_zero;
        test_signed;
        test_ignore_start;
        test_back_to_back;
        test_reset_midop;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
